// File: rtl/serial_piso_tx.sv
// serial_piso_tx: parallel-in serial-out transmitter, start/data(LSB first)/stop framing.
// Define SERIAL_PISO_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_piso_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;

`ifdef SERIAL_PISO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_q, par_d;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_out_q, tx_out_d;
    logic              done_q, done_d;
    logic              last;

    assign last     = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign tx_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign tx_out   = tx_out_q;
    assign done     = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_out_q <= 1'b1;
            done_q   <= 1'b0;
`ifdef SERIAL_PISO_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_out_q <= tx_out_d;
            done_q   <= done_d;
`ifdef SERIAL_PISO_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // tx_out is registered, so each branch loads the level of the bit that starts on this edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_out_d = tx_out_q;
        done_d   = 1'b0;
`ifdef SERIAL_PISO_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != IDLE)
            cnt_d = last ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                if (tx_valid) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    cnt_d    = '0;
                    idx_d    = '0;
                    tx_out_d = 1'b0;
`ifdef SERIAL_PISO_TX_PARITY_EN
                    par_d    = ^tx_data;
`endif
                end
            end
            START: if (last) begin
                state_d  = DATA;
                tx_out_d = shift_q[0];
            end
            DATA: if (last) begin
                shift_d = shift_q >> 1;
                if (idx_q == IW'(DATA_W - 1)) begin
`ifdef SERIAL_PISO_TX_PARITY_EN
                    state_d  = PARITY;
                    tx_out_d = par_q;
`else
                    state_d  = STOP;
                    tx_out_d = 1'b1;
`endif
                end else begin
                    idx_d    = idx_q + 1'b1;
                    tx_out_d = shift_d[0];
                end
            end
`ifdef SERIAL_PISO_TX_PARITY_EN
            PARITY: if (last) begin
                state_d  = STOP;
                tx_out_d = 1'b1;
            end
`endif
            STOP: if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_piso_tx.sv
// tb_serial_piso_tx: scoreboard bench; stimulus queues expected serial frames, a monitor
// samples tx_out while busy and checks each frame when done pulses.
module tb_serial_piso_tx;
    localparam int CPB = 4;
`ifdef SERIAL_PISO_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 11;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_out, busy, done;
    int         tests = 0;
    int         fails = 0;
    logic [0:10] exp_q[$];
    logic        sbuf[$];

    serial_piso_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // f lists start, d0..d7, stop in transmission order; p is the hand-computed parity bit.
    function automatic logic [0:10] frame(input logic [0:9] f, input logic p);
        return PAR ? {f[0:8], p, f[9]} : {f, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) sbuf.delete();
        else begin
            if (busy) sbuf.push_back(tx_out);
            if (done) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: done pulsed with %0d samples, no frame queued", sbuf.size());
                end else begin
                    logic [0:10] e, a;
                    bit ok;
                    e = exp_q.pop_front();
                    a = '0;
                    ok = sbuf.size() == FL;
                    for (int i = 0; i < NB; i++)
                        for (int j = 0; j < CPB; j++)
                            if (i * CPB + j >= sbuf.size() || sbuf[i*CPB+j] !== e[i]) ok = 1'b0;
                    for (int i = 0; i < NB; i++)
                        if (i * CPB + 1 < sbuf.size()) a[i] = sbuf[i*CPB+1];
                    if (!ok) begin
                        fails++;
                        $display("FAIL frame: got bits %b over %0d cycles, expected %b over %0d cycles",
                                 a[0:NB-1], sbuf.size(), e[0:NB-1], FL);
                    end
                end
                check("ready_in_done", tx_ready, 1);
                sbuf.delete();
            end
        end
    end

    task automatic wait_done(output int nb, output int dk, output logic f0);
        nb = 0;
        dk = -1;
        f0 = 1'bx;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) f0 = tx_out;
            if (done) begin
                dk = k;
                break;
            end
            if (busy) nb++;
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [0:10] e, input bit push);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", tx_ready, 1);
        tx_data = w;
        tx_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, dk, b1, d1, b2, d2;
        logic f0, f1, f2;
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", tx_ready, 1);

        // Accepted on the first edge after reset release.
        reset = 1'b1;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        exp_q.push_back(frame(10'b0101001011, 1'b0));
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_done(nb, dk, f0);
        check("a5_start_latency", f0, 0);
        check("a5_busy_cycles", nb, FL);
        check("a5_done_cycle", dk, FL);

        send(8'h07, frame(10'b0111000001, 1'b1), 1'b1);
        wait_done(nb, dk, f0);
        check("07_done_cycle", dk, FL);

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        exp_q.push_back(frame(10'b0000000001, 1'b0));
        exp_q.push_back(frame(10'b0111111111, 1'b0));
        @(posedge clk);
        #1 tx_data = 8'hFF;
        wait_done(b1, d1, f1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_done(b2, d2, f2);
        check("b2b_first_done", d1, FL);
        check("b2b_second_start", f2, 0);
        check("b2b_busy_total", b1 + b2, 2 * FL);
        check("b2b_second_done", d2, FL);

        // Inputs change while busy must not affect the frame.
        send(8'hF0, frame(10'b0000011111, 1'b0), 1'b1);
        tx_data = 8'h00;
        repeat (5) @(posedge clk);
        #1 tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_done(nb, dk, f0);
        check("f0_done_cycle", dk, FL - 6);

        // Reset during data bit 3 of 8'h3C.
        send(8'h3C, '0, 1'b0);
        repeat (16) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_tx_out", tx_out, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        tx_data = 8'h81;
        tx_valid = 1'b1;
        exp_q.push_back(frame(10'b0100000011, 1'b0));
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_done(nb, dk, f0);
        check("81_start", f0, 0);
        check("81_done_cycle", dk, FL);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {tx_out, busy, done, tx_ready}, 4'b1001);
            tx_data = 8'($urandom);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_piso_tx.md
SERIAL_PISO_TX -- requirements
Module: serial_piso_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port tx_data  input  DATA_W  parallel word to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data holds a word for transmission.
REQ-007 SHALL have port tx_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port tx_out  output  1  serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 SHALL assert tx_ready only in IDLE, combinationally from state.
REQ-013 SHALL accept a word on a rising edge where tx_valid=1 and tx_ready=1; tx_data captured into internal shift register on that edge.
REQ-014 SHALL move IDLE->START on the accepting edge and drive tx_out=0 from that edge (zero-cycle latency to start bit).
REQ-015 SHALL hold every frame bit on tx_out for exactly CLKS_PER_BIT cycles, timed by an internal bit-cycle counter that wraps 0..CLKS_PER_BIT-1.
REQ-016 SHALL send DATA_W data bits LSB first in DATA, tracked by a bit index counter 0..DATA_W-1.
REQ-017 SHALL drive tx_out=1 in STOP for CLKS_PER_BIT cycles.
REQ-018 SHALL, on the edge ending STOP, return to IDLE and assert done=1 for exactly that following cycle; tx_ready=1 in the same cycle.
REQ-019 SHALL accept a new word in the done cycle if tx_valid=1 (back-to-back frames, no extra idle cycles).
REQ-020 SHALL assert busy=1 in every state except IDLE.
REQ-021 SHALL ignore tx_data and tx_valid changes while busy=1; the frame in flight uses the captured word.
REQ-022 SHALL hold tx_out=1 in IDLE regardless of tx_data.
REQ-023 SHALL produce total frame length (2+DATA_W)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.

Reset
REQ-024 SHALL, while reset=0, immediately force state=IDLE, tx_out=1, busy=0, done=0, counters=0, shift register=0.
REQ-025 SHALL abort any frame on reset mid-operation with no done pulse; the word is discarded.
REQ-026 SHALL allow acceptance on the first rising edge after reset deasserts if tx_valid=1.

Configuration
REQ-027 SHALL, when macro SERIAL_PISO_TX_PARITY_EN is defined, insert PARITY state between DATA and STOP, sending even parity (XOR of captured data bits) for CLKS_PER_BIT cycles.
REQ-028 SHALL, without SERIAL_PISO_TX_PARITY_EN, contain no PARITY state or parity logic; DATA goes directly to STOP.

Verification (DATA_W=8, CLKS_PER_BIT=4)
REQ-029 SHALL check single frame: tx_data=8'hA5, tx_valid one cycle after reset -> tx_out: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4 cycles; done pulses at cycle 40 after accept; busy high 40 cycles.
REQ-030 SHALL check back-to-back: tx_valid held high with 8'h00 then 8'hFF -> second start bit begins the cycle after done, 80 cycles total, no idle high gap between frames beyond the stop bit.
REQ-031 SHALL check mid-frame reset: reset=0 during data bit 3 of 8'h3C -> tx_out=1, busy=0, tx_ready=1 immediately; no done pulse; next frame 8'h81 transmits correctly.
REQ-032 SHALL check data stability: tx_data changed to 8'h00 during frame of 8'hF0 -> serial bits still 0,0,0,0,1,1,1,1.
REQ-033 SHALL check parity with SERIAL_PISO_TX_PARITY_EN: 8'hA5 -> parity bit 0, 8'h07 -> parity bit 1; frame 44 cycles, done at cycle 44.
REQ-034 SHALL check idle behaviour: tx_valid=0 for 20 cycles with varying tx_data -> tx_out=1, busy=0, done=0, tx_ready=1 throughout.
